spi_modport_slave: RTL and testbench
====================================

Name: spi_modport_slave

Overview:
- SPI slave endpoint attached to the slave modport of the spi_bus interface: inputs clk, rst_n, cs_n, sck, mosi; output miso.
- Decodes one command byte per frame, then performs burst writes into, or burst reads from, a small internal register file.
- Fully synchronous to the system clock: sck, cs_n and mosi are oversampled, never used as clocks.
- SPI mode 0 only (CPOL=0, CPHA=0), MSB first.

Parameters:
- DATA_W, 8, register and SPI byte width.
- ADDR_W, 4, register address width (16 registers).
- ID_VAL, 8'hA5, constant returned by the read-only ID register at the top address (0xF).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- cs_n  input  1  chip select, active low; frames a transaction.
- sck  input  1  SPI clock from master; idles low.
- mosi  input  1  master-out data, valid on sck rising edge.
- miso  output  1  slave-out data, changes after sck falling edge.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Synchroniser: 2-flop synchronisers on sck, cs_n and mosi; edge detect on the synchronised sck and cs_n.
- Timing constraint: sck high and low phases must each be ≥4 clk cycles.
- Latency: mosi is sampled 2 clk after sck rises at the pin; miso updates 3 clk after sck falls at the pin.
- Reset: state IDLE, bit counter 0, shift registers 0, miso 0, registers 0x0–0xE = 0x00.
- States: IDLE, CMD, WDATA, RDATA.
- IDLE→CMD on synchronised cs_n high→low; clears bit counter and rx shift register.
- Shifting: every synchronised sck rising edge while cs_n is low shifts mosi into rx_shift LSB (MSB-first byte) and increments bit_cnt (3 bits).
- CMD, on completion of the 8th bit:
  - bit7 = 1 means write, 0 means read; bits[ADDR_W-1:0] = start address; remaining bits ignored.
  - Write → WDATA.
  - Read → load tx_shift with reg[addr], addr+1, → RDATA.
- WDATA:
  - Each completed byte writes reg[addr] and increments addr.
  - addr wraps modulo 16.
  - Writes to 0xF are discarded, but addr still increments.
- RDATA:
  - On each sck falling edge: miso <= tx_shift[DATA_W-1], then tx_shift shifts left.
  - After the 8th falling edge of a byte, tx_shift reloads reg[addr] and addr increments (wraps).
  - Reads of 0xF return ID_VAL.
  - mosi content is ignored.
- cs_n rising (any state, mid-byte included): abort to IDLE, discard partial byte (no write), miso <= 0 on the next clk.
- miso is 0 whenever not in RDATA.
- sck edges while cs_n is high are ignored.
- Simultaneous cs_n rise and 8th sck edge in the same synchronised cycle: cs_n wins; the byte is not committed.
- rst_n asserted mid-frame: immediate return to reset values, including register contents.

Decomposition:
- Shared package spi_slave_pkg holds:
  - state enum (IDLE, CMD, WDATA, RDATA);
  - CMD_WR_BIT = 7;
  - ID_ADDR = 4'hF;
  - ID_VAL default.
- One natural sub-module: spi_sync_edge, a 2-flop synchroniser plus rise/fall pulse outputs, instantiated for sck and cs_n (mosi uses the synchroniser only).
- Register file and FSM stay in the top module.

Test Plan:
- Reset: hold rst_n low → miso=0; then read 0x00..0x0E one by one → all 0x00; read 0x0F → 0xA5.
- Single write/read: frame 0x83,0x5A; new frame 0x03 + 8 dummy sck → miso shifts out 0x5A (0,1,0,1,1,0,1,0).
- Burst with wrap: write 0x8D,0x11,0x22,0x33,0x44 → reg D=0x11, E=0x22, F still reads 0xA5, reg 0=0x44; burst read from 0x0D for 4 bytes → 0x11,0x22,0xA5,0x44.
- Abort: frame 0x84 followed by 4 data bits then cs_n high → reg4 remains 0x00; next frame decodes cleanly from bit 0.
- Reset mid-read: during a read of reg3=0x5A, pulse rst_n low after 3 data bits → miso=0 immediately; reg3 reads 0x00 afterwards.
- Idle sck: toggle sck 16 times with cs_n high and mosi=1 → no register changes, miso stays 0.

Source files
------------

// File: rtl/spi_slave_pkg.sv
// Shared definitions for the SPI slave endpoint.
// Contents: FSM state encoding, command-byte layout, ID register address
// and the default ID value returned by reads of that address.
package spi_slave_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    WDATA,
    RDATA
  } state_e;

  // Bit of the command byte that selects write (1) or read (0).
  localparam int CMD_WR_BIT = 7;

  // Topmost register address is the read-only ID register.
  localparam logic [3:0] ID_ADDR = 4'hF;

  localparam logic [7:0] ID_VAL_DEFAULT = 8'hA5;

endpackage

// File: rtl/spi_modport_slave_if.sv
// SPI bus bundle shared between an SPI master and the slave endpoint.
// Signals: cs_n (chip select, active low), sck (SPI clock, idles low),
//          mosi (master-out data), miso (slave-out data).
// Modports: master drives cs_n/sck/mosi and reads miso; slave is the mirror.
interface spi_bus;
  import spi_slave_pkg::*;

  logic cs_n;
  logic sck;
  logic mosi;
  logic miso;

  modport master (output cs_n, output sck, output mosi, input miso);
  modport slave  (input cs_n, input sck, input mosi, output miso);

endinterface

// File: rtl/spi_modport_slave_sync_edge.sv
// spi_sync_edge: 2-flop synchroniser for an asynchronous input, followed by
// one extra flop so that single-cycle rise/fall pulses can be produced.
// Ports:
//   clk     - system clock
//   rst_n   - asynchronous active-low reset
//   d_i     - asynchronous input from the pin
//   level_o - synchronised level (2 clk after the pin)
//   rise_o  - one-cycle pulse when level_o goes 0->1
//   fall_o  - one-cycle pulse when level_o goes 1->0
module spi_sync_edge
  import spi_slave_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  // [0] and [1] form the synchroniser; [2] is the previous synchronised
  // value used only for edge detection.
  logic [2:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {3{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[1:0], d_i};
    end
  end

  assign level_o = sync_q[1];
  assign rise_o  = sync_q[1] & ~sync_q[2];
  assign fall_o  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/spi_modport_slave.sv
// spi_modport_slave: SPI mode-0 slave endpoint with a small register file.
// Each frame starts with a command byte (bit 7 = write, low bits = start
// address), followed by burst write or burst read data. Addresses wrap and
// the top address is a read-only ID register. All SPI pins are oversampled
// on clk; sck is never used as a clock.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   bus   - spi_bus slave modport (cs_n, sck, mosi in; miso out)
module spi_modport_slave
  import spi_slave_pkg::*;
#(
  parameter int                DATA_W = 8,
  parameter int                ADDR_W = 4,
  parameter logic [DATA_W-1:0] ID_VAL = ID_VAL_DEFAULT
) (
  input  logic     clk,
  input  logic     rst_n,
  spi_bus.slave    bus
);

  localparam int                NumRegs = 1 << ADDR_W;
  localparam int                CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0]   LastBit = CntW'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] IdAddr  = ADDR_W'(ID_ADDR);

  logic csHigh, csFall, cs_rise_unused;
  logic sckRise, sckFall, sck_level_unused;
  logic mosiSync, mosi_rise_unused, mosi_fall_unused;

  spi_sync_edge #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .d_i(bus.cs_n),
    .level_o(csHigh), .rise_o(cs_rise_unused), .fall_o(csFall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_sck (
    .clk(clk), .rst_n(rst_n), .d_i(bus.sck),
    .level_o(sck_level_unused), .rise_o(sckRise), .fall_o(sckFall)
  );

  spi_sync_edge #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .d_i(bus.mosi),
    .level_o(mosiSync), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused)
  );

  state_e              state_q, state_d;
  logic [CntW-1:0]     bitCnt_q, bitCnt_d;
  // Only the low DATA_W-1 bits are kept: the incoming mosi bit completes
  // the byte combinationally, so the oldest bit is never needed again.
  logic [DATA_W-2:0]   rxShift_q, rxShift_d;
  logic [DATA_W-1:0]   txShift_q, txShift_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                miso_q, miso_d;
  logic [DATA_W-1:0]   regs_q [NumRegs];

  logic [DATA_W-1:0]   rxByte;
  logic [ADDR_W-1:0]   cmdAddr;
  logic [DATA_W-1:0]   rdCur, rdCmd;
  logic                wrEn;

  assign rxByte  = {rxShift_q, mosiSync};
  assign cmdAddr = rxByte[ADDR_W-1:0];
  assign rdCur   = (addr_q == IdAddr) ? ID_VAL : regs_q[addr_q];
  assign rdCmd   = (cmdAddr == IdAddr) ? ID_VAL : regs_q[cmdAddr];
  assign bus.miso = miso_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      rxShift_q <= '0;
      txShift_q <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      rxShift_q <= rxShift_d;
      txShift_q <= txShift_d;
      addr_q    <= addr_d;
      miso_q    <= miso_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regs_q[i] <= '0;
    end else if (wrEn) begin
      regs_q[addr_q] <= rxByte;
    end
  end

  // A high synchronised cs_n dominates everything: it aborts any frame,
  // drops a partial byte and also masks sck edges seen while deselected.
  // This also makes cs_n win over a coincident 8th sck edge.
  always_comb begin
    state_d   = state_q;
    bitCnt_d  = bitCnt_q;
    rxShift_d = rxShift_q;
    txShift_d = txShift_q;
    addr_d    = addr_q;
    miso_d    = 1'b0;
    wrEn      = 1'b0;

    if (csHigh) begin
      state_d  = IDLE;
      bitCnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (csFall) begin
            state_d   = CMD;
            bitCnt_d  = '0;
            rxShift_d = '0;
          end
        end

        CMD: begin
          if (sckRise) begin
            rxShift_d = rxByte[DATA_W-2:0];
            bitCnt_d  = bitCnt_q + 1'b1;
            if (bitCnt_q == LastBit) begin
              if (rxByte[CMD_WR_BIT]) begin
                state_d = WDATA;
                addr_d  = cmdAddr;
              end else begin
                state_d   = RDATA;
                txShift_d = rdCmd;
                addr_d    = cmdAddr + 1'b1;
              end
            end
          end
        end

        WDATA: begin
          if (sckRise) begin
            rxShift_d = rxByte[DATA_W-2:0];
            bitCnt_d  = bitCnt_q + 1'b1;
            if (bitCnt_q == LastBit) begin
              wrEn   = (addr_q != IdAddr);
              addr_d = addr_q + 1'b1;
            end
          end
        end

        RDATA: begin
          // In read mode the counter tracks falling edges, since those
          // are the points where a byte's bits are handed out on miso.
          miso_d = miso_q;
          if (sckFall) begin
            miso_d    = txShift_q[DATA_W-1];
            txShift_d = {txShift_q[DATA_W-2:0], 1'b0};
            bitCnt_d  = bitCnt_q + 1'b1;
            if (bitCnt_q == LastBit) begin
              txShift_d = rdCur;
              addr_d    = addr_q + 1'b1;
            end
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_modport_slave.sv
// Self-checking bench for spi_modport_slave. Acts as an SPI mode-0 master
// with sck phases of 6 clk, keeps a register model and a queue of expected
// read bytes, and compares every received byte against it.
module tb_spi_modport_slave;
  import spi_slave_pkg::*;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] wdata;
    logic [7:0] expData;
    string      name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;

  spi_bus bus ();

  spi_modport_slave #(
    .DATA_W(8),
    .ADDR_W(4),
    .ID_VAL(8'hA5)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int         checkCount = 0;
  int         passCount  = 0;
  logic [7:0] expQ [$];

  task automatic waitClk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [7:0] actual,
                             input logic [7:0] required);
    checkCount++;
    if (actual === required) passCount++;
    else $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, required);
  endtask

  task automatic xferBit(input logic b, output logic m);
    bus.mosi = b;
    waitClk(6);
    bus.sck = 1'b1;
    waitClk(3);
    m = bus.miso;
    waitClk(3);
    bus.sck = 1'b0;
  endtask

  task automatic xferByte(input logic [7:0] tx, output logic [7:0] rx);
    logic m;
    for (int i = 7; i >= 0; i--) begin
      xferBit(tx[i], m);
      rx[i] = m;
    end
  endtask

  task automatic startFrame();
    bus.cs_n = 1'b0;
    waitClk(6);
  endtask

  task automatic endFrame();
    waitClk(6);
    bus.cs_n = 1'b1;
    bus.mosi = 1'b0;
    waitClk(8);
  endtask

  task automatic applyStimulus(input logic [3:0] addr, input logic [7:0] data [$]);
    logic [7:0] dummy;
    startFrame();
    xferByte({4'b1000, addr}, dummy);
    foreach (data[i]) xferByte(data[i], dummy);
    endFrame();
  endtask

  // Expected bytes are queued when the read command goes out and popped as
  // each data byte arrives on miso.
  task automatic readBurst(input logic [3:0] addr, input logic [7:0] exp [$],
                           input string name);
    logic [7:0] r;
    int n;
    n = exp.size();
    foreach (exp[i]) expQ.push_back(exp[i]);
    startFrame();
    xferByte({4'b0000, addr}, r);
    for (int i = 0; i < n; i++) begin
      xferByte(8'h00, r);
      if (expQ.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL %s[%0d]: got 0x%02h, expected nothing queued", name, i, r);
      end else begin
        checkOutput($sformatf("%s[%0d]", name, i), r, expQ.pop_front());
      end
    end
    endFrame();
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t       resetVecs [16];
    vec_t       wrVecs [5];
    logic [7:0] q [$];
    logic [7:0] dummy;
    logic       m;
    int         badIdle;

    for (int i = 0; i < 16; i++) begin
      resetVecs[i] = '{4'(i), 8'h00, (i == 15) ? 8'hA5 : 8'h00, $sformatf("reset_r%0d", i)};
    end
    wrVecs[0] = '{4'h1, 8'hC3, 8'hC3, "wr_r1"};
    wrVecs[1] = '{4'hF, 8'h00, 8'hA5, "wr_id_discard"};
    wrVecs[2] = '{4'h7, 8'hFF, 8'hFF, "wr_r7"};
    wrVecs[3] = '{4'h0, 8'h01, 8'h01, "wr_r0"};
    wrVecs[4] = '{4'hE, 8'h80, 8'h80, "wr_rE"};

    rst_n    = 1'b0;
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    bus.mosi = 1'b0;
    waitClk(4);
    checkOutput("miso_in_reset", {7'b0, bus.miso}, 8'h00);
    rst_n = 1'b1;
    waitClk(4);

    $display("[TB] reset values");
    for (int i = 0; i < 16; i++) begin
      q = {resetVecs[i].expData};
      readBurst(resetVecs[i].addr, q, resetVecs[i].name);
    end

    $display("[TB] single write/read vectors");
    for (int i = 0; i < 5; i++) begin
      q = {wrVecs[i].wdata};
      applyStimulus(wrVecs[i].addr, q);
      q = {wrVecs[i].expData};
      readBurst(wrVecs[i].addr, q, wrVecs[i].name);
    end

    $display("[TB] write 0x5A to reg 3 and read back");
    q = {8'h5A};
    applyStimulus(4'h3, q);
    readBurst(4'h3, q, "r3_5A");

    $display("[TB] burst write with wrap");
    q = {8'h11, 8'h22, 8'h33, 8'h44};
    applyStimulus(4'hD, q);
    q = {8'h11, 8'h22, 8'hA5, 8'h44};
    readBurst(4'hD, q, "burst_wrap");

    $display("[TB] abort mid-byte");
    startFrame();
    xferByte(8'h84, dummy);
    for (int i = 0; i < 4; i++) xferBit(1'b1, m);
    waitClk(2);
    bus.cs_n = 1'b1;
    waitClk(8);
    q = {8'h00};
    readBurst(4'h4, q, "abort_r4");
    q = {8'h3C};
    applyStimulus(4'h4, q);
    readBurst(4'h4, q, "after_abort_r4");

    $display("[TB] reset during read");
    startFrame();
    xferByte(8'h03, dummy);
    for (int i = 0; i < 3; i++) xferBit(1'b0, m);
    waitClk(6);
    checkOutput("miso_before_reset", {7'b0, bus.miso}, 8'h01);
    rst_n = 1'b0;
    #1;
    checkOutput("miso_async_reset", {7'b0, bus.miso}, 8'h00);
    bus.cs_n = 1'b1;
    bus.sck  = 1'b0;
    waitClk(3);
    rst_n = 1'b1;
    waitClk(4);
    q = {8'h00};
    readBurst(4'h3, q, "r3_after_reset");
    readBurst(4'h0, q, "r0_after_reset");

    $display("[TB] sck toggling while deselected");
    q = {8'h99};
    applyStimulus(4'h2, q);
    bus.mosi = 1'b1;
    badIdle  = 0;
    for (int i = 0; i < 16; i++) begin
      bus.sck = 1'b1;
      waitClk(6);
      if (bus.miso !== 1'b0) badIdle++;
      bus.sck = 1'b0;
      waitClk(6);
      if (bus.miso !== 1'b0) badIdle++;
    end
    bus.mosi = 1'b0;
    checkOutput("miso_idle_sck", 8'(badIdle), 8'h00);
    q = {8'h99};
    readBurst(4'h2, q, "idle_r2");
    q = {8'h00};
    readBurst(4'h0, q, "idle_r0");
    q = {8'hA5};
    readBurst(4'hF, q, "idle_id");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
